// File: rtl/seven_seg_scan_ctrl_if.sv
// Handshake bundle between the result registers and the display scanner.
// The master drives values and display controls; the slave drives the pins.
interface seven_seg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
) ();
    localparam int IW = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] value;
    logic                    load;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    lzb_en;
    logic [6:0]              seg;
    logic [NUM_DIGITS-1:0]   an;
    logic [IW-1:0]           digit_idx;
    logic                    frame_done;

    modport master (
        output value, load, blank_mask, lzb_en,
        input  seg, an, digit_idx, frame_done
    );

    modport slave (
        input  value, load, blank_mask, lzb_en,
        output seg, an, digit_idx, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scanner sharing one hex decoder across digits,
// with dead-time gaps, frame-aligned value commits and digit blanking.
module hex (
    input  logic [3:0] in,
    output logic [6:0] out
);
    // segment order gfedcba, active-high
    always_comb begin
        out = 7'h00;
        case (in)
            4'h0: out = 7'h3F;
            4'h1: out = 7'h06;
            4'h2: out = 7'h5B;
            4'h3: out = 7'h4F;
            4'h4: out = 7'h66;
            4'h5: out = 7'h6D;
            4'h6: out = 7'h7D;
            4'h7: out = 7'h07;
            4'h8: out = 7'h7F;
            4'h9: out = 7'h6F;
            4'hA: out = 7'h77;
            4'hB: out = 7'h7C;
            4'hC: out = 7'h39;
            4'hD: out = 7'h5E;
            4'hE: out = 7'h79;
            4'hF: out = 7'h71;
            default: out = 7'h00;
        endcase
    end
endmodule

module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int ON_TICKS   = 50000,
    parameter int GAP_TICKS  = 500,
    parameter int CNT_W      = 16
) (
    input logic                  clk,
    input logic                  reset,
    seven_seg_scan_ctrl_if.slave bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;

    localparam logic [0:0] S_GAP  = 1'b0;
    localparam logic [0:0] S_SHOW = 1'b1;

    logic [0:0]            state;
    logic [CNT_W-1:0]      cnt;
    logic [IW-1:0]         d;
    logic [VW-1:0]         pend_reg;
    logic [VW-1:0]         disp_reg;
    logic                  pend_valid;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic                  frame_done_q;

    logic                  gap_end;
    logic                  show_end;
    logic                  last_d;
    logic                  commit;
    logic [3:0]            cur_nib;
    logic [6:0]            cur_seg;
    logic                  blank_now;
    logic                  acc;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [NUM_DIGITS-1:0] an_on;

    assign gap_end  = (state == S_GAP) &&
                      (cnt == CNT_W'(GAP_TICKS - 1));
    assign show_end = (state == S_SHOW) &&
                      (cnt == CNT_W'(ON_TICKS - 1));
    assign last_d   = (d == IW'(NUM_DIGITS - 1));
    assign commit   = show_end && last_d;
    assign an_on    = ~(NUM_DIGITS'(1) << d);

    // upper_zero[k]: every nibble at index >= k is zero
    always_comb begin
        acc        = 1'b1;
        upper_zero = '0;
        cur_nib    = 4'h0;
        blank_now  = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            acc = acc & (disp_reg[4*k +: 4] == 4'h0);
            upper_zero[k] = acc;
        end
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (d == IW'(k)) begin
                cur_nib   = disp_reg[4*k +: 4];
                blank_now = bus.blank_mask[k] |
                            (bus.lzb_en & (k != 0) & upper_zero[k]);
            end
        end
    end

    hex u_hex (
        .in  (cur_nib),
        .out (cur_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_GAP;
            cnt          <= '0;
            d            <= '0;
            pend_reg     <= '0;
            disp_reg     <= '0;
            pend_valid   <= 1'b0;
            an_q         <= '1;
            seg_q        <= 7'h00;
            frame_done_q <= 1'b0;
        end else begin
            unique case (1'b1)
                gap_end: begin
                    state <= S_SHOW;
                    cnt   <= '0;
                    an_q  <= blank_now ? '1 : an_on;
                    seg_q <= blank_now ? 7'h00 : cur_seg;
                end
                show_end: begin
                    state <= S_GAP;
                    cnt   <= '0;
                    d     <= last_d ? '0 : d + IW'(1);
                    an_q  <= '1;
                    seg_q <= 7'h00;
                end
                default: cnt <= cnt + CNT_W'(1);
            endcase
            frame_done_q <= commit;
            // commit sees the old pend_reg even when load fires now
            if (commit && pend_valid)
                disp_reg <= pend_reg;
            if (bus.load) begin
                pend_reg   <= bus.value;
                pend_valid <= 1'b1;
            end else if (commit) begin
                pend_valid <= 1'b0;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.digit_idx  = d;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: time-based reference model checked every
// cycle, plus literal expectations at hand-picked cycles.
module tb_seven_seg_scan_ctrl;
    localparam int ND    = 4;
    localparam int ON    = 4;
    localparam int GAP   = 1;
    localparam int SLOT  = ON + GAP;
    localparam int FRAME = ND * SLOT;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) dut_if ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .ON_TICKS   (ON),
        .GAP_TICKS  (GAP),
        .CNT_W      (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] hex_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    // Model: outputs follow from time since reset and frame-boundary commits.
    int          t;
    bit          m_ok;
    bit          m_pv;
    logic [15:0] m_pend;
    logic [15:0] m_disp;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    int          e_idx;
    bit          e_fd;

    initial begin
        int ph;
        int dg;
        bit bl;
        logic [3:0] nib;
        m_ok = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                t = 0; m_pend = '0; m_disp = '0; m_pv = 1'b0;
                e_an = 4'hF; e_seg = 7'h00; e_idx = 0; e_fd = 1'b0;
                m_ok = 1'b1;
            end else if (m_ok) begin
                t++;
                ph = t % SLOT;
                dg = (t / SLOT) % ND;
                e_fd = (t % FRAME) == 0;
                if (e_fd && m_pv) begin
                    m_disp = m_pend;
                    m_pv = 1'b0;
                end
                if (dut_if.load) begin
                    m_pend = dut_if.value;
                    m_pv = 1'b1;
                end
                e_idx = dg;
                if (ph < GAP) begin
                    e_an = 4'hF;
                    e_seg = 7'h00;
                end else if (ph == GAP) begin
                    nib = 4'((m_disp >> (4 * dg)) & 16'hF);
                    bl = dut_if.blank_mask[dg] ||
                         (dut_if.lzb_en && dg != 0 &&
                          (m_disp >> (4 * dg)) == 16'h0);
                    e_an = bl ? 4'hF : ~(4'(1) << dg);
                    e_seg = bl ? 7'h00 : hex_of(nib);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                checks += 4;
                if (dut_if.an !== e_an) begin
                    errors++;
                    $display("FAIL model_an t=%0d got %b want %b",
                             t, dut_if.an, e_an);
                end
                if (dut_if.seg !== e_seg) begin
                    errors++;
                    $display("FAIL model_seg t=%0d got %h want %h",
                             t, dut_if.seg, e_seg);
                end
                if (int'(dut_if.digit_idx) != e_idx ||
                    $isunknown(dut_if.digit_idx)) begin
                    errors++;
                    $display("FAIL model_idx t=%0d got %0d want %0d",
                             t, dut_if.digit_idx, e_idx);
                end
                if (dut_if.frame_done !== e_fd) begin
                    errors++;
                    $display("FAIL model_fd t=%0d got %b want %b",
                             t, dut_if.frame_done, e_fd);
                end
            end
        end
    end

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0d got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic lit(input string nm, input logic [3:0] an_e,
                       input logic [6:0] seg_e);
        chk({nm, "_an"}, 32'(dut_if.an), 32'(an_e));
        chk({nm, "_seg"}, 32'(dut_if.seg), 32'(seg_e));
    endtask

    task automatic do_load(input logic [15:0] v);
        dut_if.load = 1'b1;
        dut_if.value = v;
        go_to(cyc + 1);
        dut_if.load = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc = 0;
        reset = 1'b1;
        dut_if.value = '0;
        dut_if.load = 1'b0;
        dut_if.blank_mask = '0;
        dut_if.lzb_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        lit("rst", 4'hF, 7'h00);
        chk("rst_idx", 32'(dut_if.digit_idx), 0);
        chk("rst_fd", 32'(dut_if.frame_done), 0);
        go_to(1);  lit("d0_c1", 4'hE, 7'h3F);
        go_to(3);  do_load(16'h12A3);
        lit("d0_c4", 4'hE, 7'h3F);
        go_to(5);  lit("gap_c5", 4'hF, 7'h00);
        go_to(6);  lit("d1_c6", 4'hD, 7'h3F);
        chk("idx_c6", 32'(dut_if.digit_idx), 1);
        go_to(20); chk("fd_c20", 32'(dut_if.frame_done), 1);
        go_to(21); chk("fd_c21", 32'(dut_if.frame_done), 0);
        lit("f1_d0", 4'hE, 7'h4F);
        go_to(26); lit("f1_d1", 4'hD, 7'h77);
        go_to(31); lit("f1_d2", 4'hB, 7'h5B);
        go_to(36); lit("f1_d3", 4'h7, 7'h06);
        go_to(40); chk("fd_c40", 32'(dut_if.frame_done), 1);

        go_to(45); do_load(16'h00F7);
        go_to(59); do_load(16'h0001);
        go_to(61); lit("f3_d0", 4'hE, 7'h07);
        go_to(66); lit("f3_d1", 4'hD, 7'h71);
        go_to(81); lit("f4_d0", 4'hE, 7'h06);
        go_to(86); lit("f4_d1", 4'hD, 7'h3F);

        go_to(90); do_load(16'h0005);
        go_to(99); dut_if.lzb_en = 1'b1;
        go_to(101); lit("lz5_d0", 4'hE, 7'h6D);
        go_to(106); lit("lz5_d1", 4'hF, 7'h00);
        go_to(110); do_load(16'h0000);
        go_to(111); lit("lz5_d2", 4'hF, 7'h00);
        go_to(116); lit("lz5_d3", 4'hF, 7'h00);
        go_to(121); lit("lz0_d0", 4'hE, 7'h3F);
        go_to(125); do_load(16'h1234);
        go_to(126); lit("lz0_d1", 4'hF, 7'h00);
        go_to(136); lit("lz0_d3", 4'hF, 7'h00);

        go_to(139);
        dut_if.lzb_en = 1'b0;
        dut_if.blank_mask = 4'b0100;
        go_to(141); lit("bm_d0", 4'hE, 7'h66);
        go_to(146); lit("bm_d1", 4'hD, 7'h4F);
        go_to(151); lit("bm_d2", 4'hF, 7'h00);
        go_to(155); lit("bm_gap", 4'hF, 7'h00);
        go_to(156); lit("bm_d3", 4'h7, 7'h06);
        go_to(159); dut_if.blank_mask = 4'b0000;
        go_to(160); chk("fd_c160", 32'(dut_if.frame_done), 1);

        go_to(165); do_load(16'h0009);
        go_to(172); lit("pre_rst_d2", 4'hB, 7'h5B);
        reset = 1'b1;
        go_to(173);
        reset = 1'b0;
        lit("mid_rst", 4'hF, 7'h00);
        chk("mid_rst_idx", 32'(dut_if.digit_idx), 0);
        chk("mid_rst_fd", 32'(dut_if.frame_done), 0);
        go_to(174); lit("post_rst_d0", 4'hE, 7'h3F);
        go_to(192); chk("fd_c192", 32'(dut_if.frame_done), 0);
        go_to(193); chk("fd_c193", 32'(dut_if.frame_done), 1);
        go_to(194); lit("pend_cleared", 4'hE, 7'h3F);

        go_to(200); do_load(16'h1111);
        go_to(205); do_load(16'h4321);
        go_to(214); lit("last_wins_d0", 4'hE, 7'h06);
        go_to(219); lit("last_wins_d1", 4'hD, 7'h5B);
        go_to(230);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
